decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_if.sv | 120 ++++++++++++
 rtl/decode_stage.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/decode_stage_if.sv
// Decode-stage shared constants and the fetch/execute bus interface.
package decode_stage_pkg;

  localparam int unsigned RISCV_WORD_WIDTH = 32;
  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam int unsigned ALU_OP_WIDTH     = 5;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = 5'd0;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = 5'd1;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = 5'd2;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = 5'd3;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_XOR  = 5'd4;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLL  = 5'd5;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRL  = 5'd6;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SRA  = 5'd7;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLT  = 5'd8;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_SLTU = 5'd9;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_EQ   = 5'd10;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_NE   = 5'd11;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTS  = 5'd12;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GES  = 5'd13;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_LTU  = 5'd14;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_GEU  = 5'd15;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_PASS = 5'd16;

  localparam logic [1:0] OPA_RF_1 = 2'd0;
  localparam logic [1:0] OPA_PC   = 2'd1;
  localparam logic [1:0] OPA_ZERO = 2'd2;
  localparam logic [1:0] OPB_RF_2 = 2'd0;
  localparam logic [1:0] OPB_IMM  = 2'd1;

  localparam logic WB_ALU = 1'b0;
  localparam logic WB_LSU = 1'b1;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // One decoded micro-op as presented to execute
  typedef struct packed {
    logic                        rf_we;
    logic                        rf_write_sel;
    logic [ALU_OP_WIDTH-1:0]     alu_op;
    logic [1:0]                  opa_sel;
    logic [1:0]                  opb_sel;
    logic                        lsu_w_en;
    logic                        lsu_r_en;
    logic                        lsu_sign_extend;
    logic [1:0]                  lsu_data_type;
    logic [RISCV_WORD_WIDTH-1:0] imm;
    logic                        jump;
    logic                        branch;
    logic                        illegal;
    logic                        mdu_en;
    logic [2:0]                  mdu_func;
    logic                        last_step;
  } uop_t;

  localparam uop_t UOP_RESET = '{alu_op: ALU_AND, last_step: 1'b1, default: '0};

endpackage

// Fetch-side and execute-side signals of the decode stage
interface decode_stage_if #(
  parameter int unsigned REG_COUNT = 32
) ();
  localparam int unsigned RW = $clog2(REG_COUNT);

  logic                                          in_valid_i;
  logic                                          in_ready_o;
  logic [decode_stage_pkg::RISCV_WORD_WIDTH-1:0] instr_i;
  logic [decode_stage_pkg::RISCV_ADDR_WIDTH-1:0] instr_addr_i;
  logic                                          flush_i;
  logic                                          out_valid_o;
  logic                                          out_ready_i;
  logic [RW-1:0]                                 rs1_o;
  logic [RW-1:0]                                 rs2_o;
  logic [RW-1:0]                                 rd_o;
  logic                                          rf_we_o;
  logic                                          rf_write_sel_o;
  logic [decode_stage_pkg::ALU_OP_WIDTH-1:0]     alu_op_o;
  logic [1:0]                                    operand_a_sel_o;
  logic [1:0]                                    operand_b_sel_o;
  logic                                          lsu_w_en_o;
  logic                                          lsu_r_en_o;
  logic                                          lsu_sign_extend_o;
  logic [1:0]                                    lsu_data_type_o;
  logic [decode_stage_pkg::RISCV_WORD_WIDTH-1:0] imm_o;
  logic [decode_stage_pkg::RISCV_ADDR_WIDTH-1:0] pc_o;
  logic                                          step_o;
  logic                                          last_step_o;
  logic                                          jump_o;
  logic                                          branch_o;
  logic                                          illegal_o;
  logic                                          mdu_en_o;
  logic [2:0]                                    mdu_func_o;

  modport slave (
    input  in_valid_i, instr_i, instr_addr_i, flush_i, out_ready_i,
    output in_ready_o, out_valid_o, rs1_o, rs2_o, rd_o, rf_we_o, rf_write_sel_o,
           alu_op_o, operand_a_sel_o, operand_b_sel_o, lsu_w_en_o, lsu_r_en_o,
           lsu_sign_extend_o, lsu_data_type_o, imm_o, pc_o, step_o, last_step_o,
           jump_o, branch_o, illegal_o, mdu_en_o, mdu_func_o
  );

  modport master (
    output in_valid_i, instr_i, instr_addr_i, flush_i, out_ready_i,
    input  in_ready_o, out_valid_o, rs1_o, rs2_o, rd_o, rf_we_o, rf_write_sel_o,
           alu_op_o, operand_a_sel_o, operand_b_sel_o, lsu_w_en_o, lsu_r_en_o,
           lsu_sign_extend_o, lsu_data_type_o, imm_o, pc_o, step_o, last_step_o,
           jump_o, branch_o, illegal_o, mdu_en_o, mdu_func_o
  );

endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: one registered micro-op per instruction, two for jumps/branches.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned REG_COUNT = 32,
  parameter bit          M_EXT     = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave dec
);

  localparam int unsigned RW = $clog2(REG_COUNT);

  if (REG_COUNT != 16 && REG_COUNT != 32) begin : g_reg_count_chk
    $error("decode_stage: REG_COUNT must be 16 or 32");
  end

  typedef enum logic [1:0] {S_IDLE, S_STEP0, S_STEP1} state_e;

  state_e                      state_q, state_d;
  logic                        out_valid_q, out_valid_d;
  logic                        step_q, step_d;
  uop_t                        uop_q, uop_d;
  logic [RW-1:0]               rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [RISCV_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [RISCV_WORD_WIDTH-1:0] instr_q, instr_d;
  logic                        in_ready_c, accept_c, out_fire_c, load_new_c;

  // Decode one micro-op of an instruction; step selects the second half of jumps/branches
  function automatic uop_t decode(input logic [RISCV_WORD_WIDTH-1:0] ins, input logic step);
    uop_t                        u;
    logic                        bad, use_rd, use_rs1, use_rs2;
    logic [2:0]                  f3;
    logic [6:0]                  f7;
    logic [RISCV_WORD_WIDTH-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
    f3     = ins[14:12];
    f7     = ins[31:25];
    imm_i  = {{20{ins[31]}}, ins[31:20]};
    imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    imm_u  = {ins[31:12], 12'b0};
    imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    imm_sh = {27'b0, ins[24:20]};
    u           = '0;
    u.alu_op    = ALU_ADD;
    u.last_step = 1'b1;
    bad         = 1'b0;
    use_rd      = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC: begin
        use_rd    = 1'b1;
        u.rf_we   = 1'b1;
        u.opa_sel = (ins[6:0] == OPC_LUI) ? OPA_ZERO : OPA_PC;
        u.opb_sel = OPB_IMM;
        u.imm     = imm_u;
      end
      OPC_JAL, OPC_JALR: begin
        use_rd      = 1'b1;
        use_rs1     = (ins[6:0] == OPC_JALR);
        bad         = (ins[6:0] == OPC_JALR) && (f3 != 3'd0);
        u.jump      = 1'b1;
        u.last_step = step;
        u.opb_sel   = OPB_IMM;
        if (!step) begin
          u.rf_we   = 1'b1;
          u.opa_sel = OPA_PC;
          u.imm     = RISCV_WORD_WIDTH'(4);
        end else if (ins[6:0] == OPC_JAL) begin
          u.opa_sel = OPA_PC;
          u.imm     = imm_j;
        end else begin
          u.opa_sel = OPA_RF_1;
          u.imm     = imm_i;
        end
      end
      OPC_BRANCH: begin
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        u.branch    = 1'b1;
        u.last_step = step;
        u.imm       = imm_b;
        if (!step) begin
          u.opa_sel = OPA_RF_1;
          u.opb_sel = OPB_RF_2;
        end else begin
          u.opa_sel = OPA_PC;
          u.opb_sel = OPB_IMM;
        end
        case (f3)
          3'd0:    u.alu_op = ALU_EQ;
          3'd1:    u.alu_op = ALU_NE;
          3'd4:    u.alu_op = ALU_LTS;
          3'd5:    u.alu_op = ALU_GES;
          3'd6:    u.alu_op = ALU_LTU;
          3'd7:    u.alu_op = ALU_GEU;
          default: bad = 1'b1;
        endcase
        if (step) u.alu_op = ALU_ADD;
      end
      OPC_LOAD: begin
        use_rd            = 1'b1;
        use_rs1           = 1'b1;
        bad               = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        u.rf_we           = 1'b1;
        u.rf_write_sel    = WB_LSU;
        u.lsu_r_en        = 1'b1;
        u.lsu_sign_extend = !f3[2];
        u.lsu_data_type   = f3[1:0];
        u.opa_sel         = OPA_RF_1;
        u.opb_sel         = OPB_IMM;
        u.imm             = imm_i;
      end
      OPC_STORE: begin
        use_rs1         = 1'b1;
        use_rs2         = 1'b1;
        bad             = f3[2] || (f3[1:0] == 2'd3);
        u.lsu_w_en      = 1'b1;
        u.lsu_data_type = f3[1:0];
        u.opa_sel       = OPA_RF_1;
        u.opb_sel       = OPB_IMM;
        u.imm           = imm_s;
      end
      OPC_OP_IMM: begin
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        u.rf_we   = 1'b1;
        u.opa_sel = OPA_RF_1;
        u.opb_sel = OPB_IMM;
        u.imm     = imm_i;
        case (f3)
          3'd0: u.alu_op = ALU_ADD;
          3'd2: u.alu_op = ALU_SLT;
          3'd3: u.alu_op = ALU_SLTU;
          3'd4: u.alu_op = ALU_XOR;
          3'd6: u.alu_op = ALU_OR;
          3'd1: begin
            u.alu_op = ALU_SLL;
            u.imm    = imm_sh;
            bad      = (f7 != 7'h00);
          end
          3'd5: begin
            u.imm = imm_sh;
            if (f7 == 7'h00)      u.alu_op = ALU_SRL;
            else if (f7 == 7'h20) u.alu_op = ALU_SRA;
            else                  bad = 1'b1;
          end
          default: u.alu_op = ALU_AND;
        endcase
      end
      OPC_OP: begin
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        u.rf_we   = 1'b1;
        u.opa_sel = OPA_RF_1;
        u.opb_sel = OPB_RF_2;
        case (f7)
          7'h00: begin
            case (f3)
              3'd0:    u.alu_op = ALU_ADD;
              3'd1:    u.alu_op = ALU_SLL;
              3'd2:    u.alu_op = ALU_SLT;
              3'd3:    u.alu_op = ALU_SLTU;
              3'd4:    u.alu_op = ALU_XOR;
              3'd5:    u.alu_op = ALU_SRL;
              3'd6:    u.alu_op = ALU_OR;
              default: u.alu_op = ALU_AND;
            endcase
          end
          7'h20: begin
            if (f3 == 3'd0)      u.alu_op = ALU_SUB;
            else if (f3 == 3'd5) u.alu_op = ALU_SRA;
            else                 bad = 1'b1;
          end
          7'h01: begin
            if (M_EXT) begin
              u.mdu_en   = 1'b1;
              u.mdu_func = f3;
              u.alu_op   = ALU_PASS;
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    if (ins[1:0] != 2'b11) bad = 1'b1;
    if (REG_COUNT == 16) begin
      bad = bad | (use_rd & ins[11]) | (use_rs1 & ins[19]) | (use_rs2 & ins[24]);
    end
    if (bad) begin
      u.rf_we     = 1'b0;
      u.lsu_w_en  = 1'b0;
      u.lsu_r_en  = 1'b0;
      u.jump      = 1'b0;
      u.branch    = 1'b0;
      u.mdu_en    = 1'b0;
      u.illegal   = 1'b1;
      u.last_step = 1'b1;
    end
    return u;
  endfunction

  // Handshake qualifiers; flush and reset both block new instructions
  assign out_fire_c = out_valid_q && dec.out_ready_i;
  assign in_ready_c = !rst && !dec.flush_i &&
                      ((state_q == S_IDLE) || (out_fire_c && uop_q.last_step));
  assign accept_c   = dec.in_valid_i && in_ready_c;

  // State register and output pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      step_q      <= 1'b0;
      uop_q       <= UOP_RESET;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      instr_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      step_q      <= step_d;
      uop_q       <= uop_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
    end
  end

  // Next state and next micro-op
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    uop_d      = uop_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    load_new_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) load_new_c = 1'b1;
      end
      S_STEP0: begin
        if (out_fire_c) begin
          if (!uop_q.last_step) begin
            state_d = S_STEP1;
            step_d  = 1'b1;
            uop_d   = decode(instr_q, 1'b1);
          end else if (accept_c) begin
            load_new_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_STEP1: begin
        if (out_fire_c) begin
          if (accept_c) load_new_c = 1'b1;
          else          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (load_new_c) begin
      state_d = S_STEP0;
      step_d  = 1'b0;
      uop_d   = decode(dec.instr_i, 1'b0);
      rs1_d   = RW'(dec.instr_i[19:15]);
      rs2_d   = RW'(dec.instr_i[24:20]);
      rd_d    = RW'(dec.instr_i[11:7]);
      pc_d    = dec.instr_addr_i;
      instr_d = dec.instr_i;
    end
    if (dec.flush_i) state_d = S_IDLE;
    out_valid_d = (state_d != S_IDLE);
  end

  // Output mapping
  assign dec.in_ready_o        = in_ready_c;
  assign dec.out_valid_o       = out_valid_q;
  assign dec.rs1_o             = rs1_q;
  assign dec.rs2_o             = rs2_q;
  assign dec.rd_o              = rd_q;
  assign dec.rf_we_o           = uop_q.rf_we;
  assign dec.rf_write_sel_o    = uop_q.rf_write_sel;
  assign dec.alu_op_o          = uop_q.alu_op;
  assign dec.operand_a_sel_o   = uop_q.opa_sel;
  assign dec.operand_b_sel_o   = uop_q.opb_sel;
  assign dec.lsu_w_en_o        = uop_q.lsu_w_en;
  assign dec.lsu_r_en_o        = uop_q.lsu_r_en;
  assign dec.lsu_sign_extend_o = uop_q.lsu_sign_extend;
  assign dec.lsu_data_type_o   = uop_q.lsu_data_type;
  assign dec.imm_o             = uop_q.imm;
  assign dec.pc_o              = pc_q;
  assign dec.step_o            = step_q;
  assign dec.last_step_o       = uop_q.last_step;
  assign dec.jump_o            = uop_q.jump;
  assign dec.branch_o          = uop_q.branch;
  assign dec.illegal_o         = uop_q.illegal;
  assign dec.mdu_en_o          = uop_q.mdu_en;
  assign dec.mdu_func_o        = uop_q.mdu_func;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench: a 32-register/no-M instance and a 16-register/M instance share stimulus.
module tb_decode_stage;
  import decode_stage_pkg::*;

  localparam logic [31:0] I_ADDI   = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_JAL    = 32'h008000EF;  // jal x1,+8
  localparam logic [31:0] I_X16    = 32'h00100813;  // addi x16,x0,1
  localparam logic [31:0] I_MUL    = 32'h022081B3;  // mul x3,x1,x2
  localparam logic [31:0] I_BEQ    = 32'h00208463;  // beq x1,x2,+8
  localparam logic [31:0] I_LW     = 32'h00C0A283;  // lw x5,12(x1)
  localparam logic [31:0] I_ECALL  = 32'h00000073;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] addr = '0;
  int          n_checks = 0;
  int          n_errors = 0;

  decode_stage_if #(.REG_COUNT(32)) if32 ();
  decode_stage_if #(.REG_COUNT(16)) if16 ();

  assign if32.in_valid_i   = in_valid;
  assign if32.instr_i      = instr;
  assign if32.instr_addr_i = addr;
  assign if32.flush_i      = flush;
  assign if32.out_ready_i  = out_ready;
  assign if16.in_valid_i   = in_valid;
  assign if16.instr_i      = instr;
  assign if16.instr_addr_i = addr;
  assign if16.flush_i      = flush;
  assign if16.out_ready_i  = out_ready;

  decode_stage #(.REG_COUNT(32), .M_EXT(1'b0)) u_dut32 (.clk(clk), .rst(rst), .dec(if32));
  decode_stage #(.REG_COUNT(16), .M_EXT(1'b1)) u_dut16 (.clk(clk), .rst(rst), .dec(if16));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    check_val("rst_out_valid", 32'(if32.out_valid_o), 32'd0);
    check_val("rst_in_ready", 32'(if32.in_ready_o), 32'd0);
    check_val("rst_alu_op", 32'(if32.alu_op_o), 32'(ALU_AND));
    check_val("rst_last_step", 32'(if32.last_step_o), 32'd1);
    check_val("rst_imm", if32.imm_o, 32'd0);
    check_val("rst_rf_we", 32'(if32.rf_we_o), 32'd0);

    // ADDI accepted on the first edge after reset release
    rst = 1'b0; in_valid = 1'b1; instr = I_ADDI; addr = 32'h100; out_ready = 1'b1;
    #1;
    check_val("addi_in_ready", 32'(if32.in_ready_o), 32'd1);
    tick();
    in_valid = 1'b0;
    check_val("addi_valid", 32'(if32.out_valid_o), 32'd1);
    check_val("addi_rd", 32'(if32.rd_o), 32'd1);
    check_val("addi_rs1", 32'(if32.rs1_o), 32'd0);
    check_val("addi_imm", if32.imm_o, 32'd5);
    check_val("addi_alu", 32'(if32.alu_op_o), 32'(ALU_ADD));
    check_val("addi_opb", 32'(if32.operand_b_sel_o), 32'(OPB_IMM));
    check_val("addi_rf_we", 32'(if32.rf_we_o), 32'd1);
    check_val("addi_last", 32'(if32.last_step_o), 32'd1);
    check_val("addi_step", 32'(if32.step_o), 32'd0);
    check_val("addi_pc", if32.pc_o, 32'h100);
    check_val("addi_illegal", 32'(if32.illegal_o), 32'd0);
    tick();
    check_val("addi_drain", 32'(if32.out_valid_o), 32'd0);

    // JAL with execute stalled three cycles
    in_valid = 1'b1; instr = I_JAL; addr = 32'h200; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("jal0_valid", 32'(if32.out_valid_o), 32'd1);
      check_val("jal0_imm", if32.imm_o, 32'd4);
      check_val("jal0_rf_we", 32'(if32.rf_we_o), 32'd1);
      check_val("jal0_step", 32'(if32.step_o), 32'd0);
      check_val("jal0_last", 32'(if32.last_step_o), 32'd0);
      check_val("jal0_jump", 32'(if32.jump_o), 32'd1);
      check_val("jal0_opa", 32'(if32.operand_a_sel_o), 32'(OPA_PC));
      check_val("jal0_in_ready", 32'(if32.in_ready_o), 32'd0);
      if (i < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    check_val("jal0_fire_in_ready", 32'(if32.in_ready_o), 32'd0);
    tick();
    check_val("jal1_valid", 32'(if32.out_valid_o), 32'd1);
    check_val("jal1_imm", if32.imm_o, 32'd8);
    check_val("jal1_rf_we", 32'(if32.rf_we_o), 32'd0);
    check_val("jal1_step", 32'(if32.step_o), 32'd1);
    check_val("jal1_last", 32'(if32.last_step_o), 32'd1);
    check_val("jal1_pc", if32.pc_o, 32'h200);
    check_val("jal1_jump", 32'(if32.jump_o), 32'd1);
    tick();
    check_val("jal_idle", 32'(if32.out_valid_o), 32'd0);

    // ten back-to-back ADDIs
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; instr = (32'(k) << 20) | 32'h093; addr = 32'h400 + 32'(4 * k);
      #1;
      check_val("b2b_in_ready", 32'(if32.in_ready_o), 32'd1);
      tick();
      check_val("b2b_valid", 32'(if32.out_valid_o), 32'd1);
      check_val("b2b_imm", if32.imm_o, 32'(k));
    end
    in_valid = 1'b0;
    tick();
    check_val("b2b_drain", 32'(if32.out_valid_o), 32'd0);

    // BEQ: compare step then target step
    in_valid = 1'b1; instr = I_BEQ; addr = 32'h600;
    tick();
    in_valid = 1'b0;
    check_val("beq0_alu", 32'(if32.alu_op_o), 32'(ALU_EQ));
    check_val("beq0_opb", 32'(if32.operand_b_sel_o), 32'(OPB_RF_2));
    check_val("beq0_branch", 32'(if32.branch_o), 32'd1);
    check_val("beq0_last", 32'(if32.last_step_o), 32'd0);
    tick();
    check_val("beq1_alu", 32'(if32.alu_op_o), 32'(ALU_ADD));
    check_val("beq1_opa", 32'(if32.operand_a_sel_o), 32'(OPA_PC));
    check_val("beq1_imm", if32.imm_o, 32'd8);
    check_val("beq1_branch", 32'(if32.branch_o), 32'd1);
    tick();
    check_val("beq_idle", 32'(if32.out_valid_o), 32'd0);

    // LW
    in_valid = 1'b1; instr = I_LW;
    tick();
    in_valid = 1'b0;
    check_val("lw_r_en", 32'(if32.lsu_r_en_o), 32'd1);
    check_val("lw_type", 32'(if32.lsu_data_type_o), 32'd2);
    check_val("lw_sext", 32'(if32.lsu_sign_extend_o), 32'd1);
    check_val("lw_wsel", 32'(if32.rf_write_sel_o), 32'd1);
    check_val("lw_imm", if32.imm_o, 32'd12);
    check_val("lw_rd", 32'(if32.rd_o), 32'd5);
    tick();

    // flush while holding JAL step 0, with a new instruction offered
    in_valid = 1'b1; instr = I_JAL; out_ready = 1'b0;
    tick();
    instr = I_ADDI; flush = 1'b1;
    #1;
    check_val("flush_in_ready", 32'(if32.in_ready_o), 32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check_val("flush_valid", 32'(if32.out_valid_o), 32'd0);
    tick();
    check_val("flush_no_accept", 32'(if32.out_valid_o), 32'd0);

    // register-count check on x16
    out_ready = 1'b1; in_valid = 1'b1; instr = I_X16;
    tick();
    in_valid = 1'b0;
    check_val("x16_r32_illegal", 32'(if32.illegal_o), 32'd0);
    check_val("x16_r32_rd", 32'(if32.rd_o), 32'd16);
    check_val("x16_r32_rf_we", 32'(if32.rf_we_o), 32'd1);
    check_val("x16_r16_illegal", 32'(if16.illegal_o), 32'd1);
    check_val("x16_r16_rf_we", 32'(if16.rf_we_o), 32'd0);
    tick();

    // MUL with and without M extension
    in_valid = 1'b1; instr = I_MUL;
    tick();
    in_valid = 1'b0;
    check_val("mul_noext_illegal", 32'(if32.illegal_o), 32'd1);
    check_val("mul_noext_mdu", 32'(if32.mdu_en_o), 32'd0);
    check_val("mul_ext_illegal", 32'(if16.illegal_o), 32'd0);
    check_val("mul_ext_mdu", 32'(if16.mdu_en_o), 32'd1);
    check_val("mul_ext_func", 32'(if16.mdu_func_o), 32'd0);
    check_val("mul_ext_rd", 32'(if16.rd_o), 32'd3);
    check_val("mul_ext_rs1", 32'(if16.rs1_o), 32'd1);
    check_val("mul_ext_rs2", 32'(if16.rs2_o), 32'd2);
    check_val("mul_ext_alu", 32'(if16.alu_op_o), 32'(ALU_PASS));
    check_val("mul_ext_rf_we", 32'(if16.rf_we_o), 32'd1);
    tick();

    // SYSTEM is illegal and single-step
    in_valid = 1'b1; instr = I_ECALL;
    tick();
    in_valid = 1'b0;
    check_val("ecall_illegal", 32'(if32.illegal_o), 32'd1);
    check_val("ecall_last", 32'(if32.last_step_o), 32'd1);
    check_val("ecall_rf_we", 32'(if32.rf_we_o), 32'd0);
    tick();

    // asynchronous reset in the middle of a held JAL
    in_valid = 1'b1; instr = I_JAL; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    check_val("prerst_valid", 32'(if32.out_valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 32'(if32.out_valid_o), 32'd0);
    check_val("arst_in_ready", 32'(if32.in_ready_o), 32'd0);
    check_val("arst_alu", 32'(if32.alu_op_o), 32'(ALU_AND));
    check_val("arst_last", 32'(if32.last_step_o), 32'd1);
    check_val("arst_jump", 32'(if32.jump_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
